// File: rtl/jux_axi4_rd_arb_pkg.sv
// Shared types for the two-requester AXI4 read arbiter: FSM states, AXI encodings,
// and the width of the requester index carried in the ID MSB.
package jux_axi4_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

    localparam int REQ_IDX_W = 1;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/jux_axi4_rd_arb_if.sv
// AR/R bundle for two requesters (s0, s1) and one shared manager port (m).
// slave = the arbiter's view, master = the surrounding environment's view.
interface jux_axi4_rd_arb_if #(
    parameter int DATA_WIDTH  = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int ID_WIDTH    = 4,
    parameter int AXLEN_WIDTH = 8
);
    localparam int DW = 8 << DATA_WIDTH;

    logic [ID_WIDTH-1:0]    s0_arid,    s1_arid;
    logic [ADDR_WIDTH-1:0]  s0_araddr,  s1_araddr;
    logic [AXLEN_WIDTH-1:0] s0_arlen,   s1_arlen;
    logic [2:0]             s0_arsize,  s1_arsize;
    logic [1:0]             s0_arburst, s1_arburst;
    logic                   s0_arvalid, s1_arvalid;
    logic                   s0_arready, s1_arready;

    logic [ID_WIDTH:0]      m_arid;
    logic [ADDR_WIDTH-1:0]  m_araddr;
    logic [AXLEN_WIDTH-1:0] m_arlen;
    logic [2:0]             m_arsize;
    logic [1:0]             m_arburst;
    logic                   m_arvalid, m_arready;

    logic [ID_WIDTH:0]      m_rid;
    logic [DW-1:0]          m_rdata;
    logic [1:0]             m_rresp;
    logic                   m_rlast, m_rvalid, m_rready;

    logic [ID_WIDTH-1:0]    s0_rid,    s1_rid;
    logic [DW-1:0]          s0_rdata,  s1_rdata;
    logic [1:0]             s0_rresp,  s1_rresp;
    logic                   s0_rlast,  s1_rlast;
    logic                   s0_rvalid, s1_rvalid;
    logic                   s0_rready, s1_rready;

    modport slave (
        input  s0_arid, s0_araddr, s0_arlen, s0_arsize, s0_arburst, s0_arvalid,
        input  s1_arid, s1_araddr, s1_arlen, s1_arsize, s1_arburst, s1_arvalid,
        output s0_arready, s1_arready,
        output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
        input  m_arready,
        input  m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
        output m_rready,
        output s0_rid, s0_rdata, s0_rresp, s0_rlast, s0_rvalid,
        output s1_rid, s1_rdata, s1_rresp, s1_rlast, s1_rvalid,
        input  s0_rready, s1_rready
    );

    modport master (
        output s0_arid, s0_araddr, s0_arlen, s0_arsize, s0_arburst, s0_arvalid,
        output s1_arid, s1_araddr, s1_arlen, s1_arsize, s1_arburst, s1_arvalid,
        input  s0_arready, s1_arready,
        input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
        output m_arready,
        output m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
        input  m_rready,
        input  s0_rid, s0_rdata, s0_rresp, s0_rlast, s0_rvalid,
        input  s1_rid, s1_rdata, s1_rresp, s1_rlast, s1_rvalid,
        output s0_rready, s1_rready
    );

endinterface

// File: rtl/jux_axi4_rd_arb_rr_arb2.sv
// Two-way round-robin grant; the pointer holds the requester with priority next,
// and moves past whichever requester was granted when i_ack is high.
module jux_rr_arb2 (
    input  logic       aclk,
    input  logic       areset_n,
    input  logic [1:0] i_req,
    input  logic       i_ack,
    output logic [1:0] o_grant
);
    logic r_ptr;

    always_comb begin
        o_grant = 2'b00;
        if (!r_ptr) o_grant = i_req[0] ? 2'b01 : (i_req[1] ? 2'b10 : 2'b00);
        else        o_grant = i_req[1] ? 2'b10 : (i_req[0] ? 2'b01 : 2'b00);
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n)                r_ptr <= 1'b0;
        else if (i_ack && |o_grant)   r_ptr <= o_grant[0];
    end

endmodule

// File: rtl/jux_axi4_rd_arb.sv
// Two-requester AXI4 read arbiter: round-robin AR grant into a registered manager
// slot, requester index in the ID MSB steers R back. Option: JUX_AXI4_RD_ARB_OUTST_LIMIT_EN.
module jux_axi4_rd_arb
    import jux_axi4_pkg::*;
#(
    parameter int DATA_WIDTH  = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int ID_WIDTH    = 4,
    parameter int AXLEN_WIDTH = 8,
    parameter int MAX_OUTST   = 4
) (
    input  logic               aclk,
    input  logic               areset_n,
    jux_axi4_rd_arb_if.slave   io_bus
);
    if (MAX_OUTST < 1) begin : g_bad_outst
        $error("MAX_OUTST must be at least 1");
    end

    arb_state_e             r_state, w_state_nxt;
    logic [1:0]             w_arvalid, w_elig, w_req, w_grant;
    logic [ID_WIDTH:0]      r_arid;
    logic [ADDR_WIDTH-1:0]  r_araddr;
    logic [AXLEN_WIDTH-1:0] r_arlen;
    logic [2:0]             r_arsize;
    logic [1:0]             r_arburst;
    logic                   w_rsel;
    logic [(8<<DATA_WIDTH)-1:0] w_rdata;

    assign w_arvalid = {io_bus.s1_arvalid, io_bus.s0_arvalid};

`ifdef JUX_AXI4_RD_ARB_OUTST_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    logic w_ar_hs, w_r_hs;
    assign w_ar_hs = (r_state == ST_HOLD) && io_bus.m_arready;
    assign w_r_hs  = io_bus.m_rvalid && io_bus.m_rready && io_bus.m_rlast;

    for (genvar n = 0; n < 2; n++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt;
        logic             w_inc, w_dec;
        assign w_inc = w_ar_hs && (r_arid[ID_WIDTH] == 1'(n));
        assign w_dec = w_r_hs  && (io_bus.m_rid[ID_WIDTH] == 1'(n));
        assign w_elig[n] = w_arvalid[n] && (r_cnt != CNT_W'(MAX_OUTST));

        // Saturating guards keep the count sane if an orphan R from before reset arrives.
        always_ff @(posedge aclk or negedge areset_n) begin
            if (!areset_n)
                r_cnt <= '0;
            else if (w_inc && !w_dec && r_cnt != CNT_W'(MAX_OUTST))
                r_cnt <= r_cnt + 1'b1;
            else if (w_dec && !w_inc && r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
        end

        a_no_underflow: assert property (@(posedge aclk) disable iff (!areset_n)
            !(w_dec && !w_inc && r_cnt == '0));
        a_no_overflow: assert property (@(posedge aclk) disable iff (!areset_n)
            !(w_inc && !w_dec && r_cnt == CNT_W'(MAX_OUTST)));
    end
`else
    assign w_elig = w_arvalid;
`endif

    // Reset gates the request so arready stays low while areset_n is asserted.
    assign w_req = (r_state == ST_IDLE && areset_n) ? w_elig : 2'b00;

    jux_rr_arb2 u_rr (
        .aclk     (aclk),
        .areset_n (areset_n),
        .i_req    (w_req),
        .i_ack    (|w_grant),
        .o_grant  (w_grant)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (|w_grant)          w_state_nxt = ST_HOLD;
            ST_HOLD: if (io_bus.m_arready)  w_state_nxt = ST_IDLE;
            default:                        w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_state   <= ST_IDLE;
            r_arid    <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_arburst <= BURST_FIXED;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant[1]) begin
                r_arid    <= {REQ_IDX_W'(1), io_bus.s1_arid};
                r_araddr  <= io_bus.s1_araddr;
                r_arlen   <= io_bus.s1_arlen;
                r_arsize  <= io_bus.s1_arsize;
                r_arburst <= io_bus.s1_arburst;
            end else if (w_grant[0]) begin
                r_arid    <= {REQ_IDX_W'(0), io_bus.s0_arid};
                r_araddr  <= io_bus.s0_araddr;
                r_arlen   <= io_bus.s0_arlen;
                r_arsize  <= io_bus.s0_arsize;
                r_arburst <= io_bus.s0_arburst;
            end
        end
    end

    assign io_bus.s0_arready = w_grant[0];
    assign io_bus.s1_arready = w_grant[1];
    assign io_bus.m_arvalid  = (r_state == ST_HOLD);
    assign io_bus.m_arid     = r_arid;
    assign io_bus.m_araddr   = r_araddr;
    assign io_bus.m_arlen    = r_arlen;
    assign io_bus.m_arsize   = r_arsize;
    assign io_bus.m_arburst  = r_arburst;

    // R payload fans out to both requesters; only rvalid/rready are steered.
    assign w_rsel  = io_bus.m_rid[ID_WIDTH];
    assign w_rdata = io_bus.m_rdata;

    assign io_bus.s0_rid    = io_bus.m_rid[ID_WIDTH-1:0];
    assign io_bus.s1_rid    = io_bus.m_rid[ID_WIDTH-1:0];
    assign io_bus.s0_rdata  = w_rdata;
    assign io_bus.s1_rdata  = w_rdata;
    assign io_bus.s0_rresp  = io_bus.m_rresp;
    assign io_bus.s1_rresp  = io_bus.m_rresp;
    assign io_bus.s0_rlast  = io_bus.m_rlast;
    assign io_bus.s1_rlast  = io_bus.m_rlast;
    assign io_bus.s0_rvalid = io_bus.m_rvalid && !w_rsel;
    assign io_bus.s1_rvalid = io_bus.m_rvalid &&  w_rsel;
    assign io_bus.m_rready  = w_rsel ? io_bus.s1_rready : io_bus.s0_rready;

endmodule

// File: tb/tb_jux_axi4_rd_arb.sv
// Directed bench for jux_axi4_rd_arb: R-routing vector table plus AR sequences
// (single grant, hold stability, alternation, reset mid-hold, optional outstanding limit).
module tb_jux_axi4_rd_arb;
    import jux_axi4_pkg::*;

    logic aclk = 1'b0;
    logic areset_n = 1'b0;
    always #5 aclk = ~aclk;

    jux_axi4_rd_arb_if bus ();

    jux_axi4_rd_arb dut (
        .aclk     (aclk),
        .areset_n (areset_n),
        .io_bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    typedef struct {
        logic [4:0]  rid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast, rvalid, s0_rready, s1_rready;
        logic        e_s0v, e_s1v, e_mrr;
    } rvec_t;

    rvec_t rv [5];

    initial begin
        //           rid    rdata          rresp        last vld s0r s1r  s0v s1v mrr
        rv[0] = '{5'h12, 32'hDEAD_BEEF, RESP_OKAY,   1, 1, 1, 0,  0, 1, 0};
        rv[1] = '{5'h12, 32'h0000_1234, RESP_SLVERR, 0, 1, 0, 1,  0, 1, 1};
        rv[2] = '{5'h05, 32'hA5A5_5A5A, RESP_EXOKAY, 1, 1, 1, 0,  1, 0, 1};
        rv[3] = '{5'h05, 32'h1111_2222, RESP_DECERR, 0, 1, 0, 1,  1, 0, 0};
        rv[4] = '{5'h1F, 32'h0,         RESP_OKAY,   0, 0, 0, 1,  0, 0, 1};

        bus.s0_arid = '0; bus.s0_araddr = '0; bus.s0_arlen = '0; bus.s0_arsize = '0;
        bus.s0_arburst = '0; bus.s0_arvalid = 1'b0;
        bus.s1_arid = '0; bus.s1_araddr = '0; bus.s1_arlen = '0; bus.s1_arsize = '0;
        bus.s1_arburst = '0; bus.s1_arvalid = 1'b0;
        bus.m_arready = 1'b0;
        bus.m_rid = '0; bus.m_rdata = '0; bus.m_rresp = '0; bus.m_rlast = 1'b0;
        bus.m_rvalid = 1'b0; bus.s0_rready = 1'b0; bus.s1_rready = 1'b0;

        // reset state, with a request pending
        bus.s0_arvalid = 1'b1;
        #12;
        chk("rst_m_arvalid", bus.m_arvalid, 0);
        chk("rst_m_arid",    bus.m_arid, 0);
        chk("rst_m_araddr",  bus.m_araddr, 0);
        chk("rst_arready",   {bus.s1_arready, bus.s0_arready}, 0);
        bus.s0_arvalid = 1'b0;
        @(negedge aclk);
        areset_n = 1'b1;

        // combinational R routing table
        for (int i = 0; i < 5; i++) begin
            bus.m_rid = rv[i].rid; bus.m_rdata = rv[i].rdata; bus.m_rresp = rv[i].rresp;
            bus.m_rlast = rv[i].rlast; bus.m_rvalid = rv[i].rvalid;
            bus.s0_rready = rv[i].s0_rready; bus.s1_rready = rv[i].s1_rready;
            #1;
            chk($sformatf("r%0d_s0_rvalid", i), bus.s0_rvalid, rv[i].e_s0v);
            chk($sformatf("r%0d_s1_rvalid", i), bus.s1_rvalid, rv[i].e_s1v);
            chk($sformatf("r%0d_m_rready", i),  bus.m_rready,  rv[i].e_mrr);
            chk($sformatf("r%0d_s0_rid", i),    bus.s0_rid,    rv[i].rid[3:0]);
            chk($sformatf("r%0d_s1_rid", i),    bus.s1_rid,    rv[i].rid[3:0]);
            chk($sformatf("r%0d_s0_rdata", i),  bus.s0_rdata,  rv[i].rdata);
            chk($sformatf("r%0d_s1_rresp", i),  bus.s1_rresp,  rv[i].rresp);
            chk($sformatf("r%0d_s1_rlast", i),  bus.s1_rlast,  rv[i].rlast);
        end
        bus.m_rvalid = 1'b0; bus.s0_rready = 1'b0; bus.s1_rready = 1'b0;

        // single s0 request
        tick();
        bus.s0_arid = 4'h3; bus.s0_araddr = 32'h100; bus.s0_arlen = 8'd3;
        bus.s0_arsize = 3'd2; bus.s0_arburst = BURST_INCR; bus.s0_arvalid = 1'b1;
        #1;
        chk("s0_arready_pulse", {bus.s1_arready, bus.s0_arready}, 2'b01);
        chk("pre_m_arvalid",    bus.m_arvalid, 0);
        tick();
        bus.s0_arvalid = 1'b0;
        #1;
        chk("hold_m_arvalid", bus.m_arvalid, 1);
        chk("hold_m_arid",    bus.m_arid, 5'h03);
        chk("hold_m_araddr",  bus.m_araddr, 32'h100);
        chk("hold_m_arlen",   bus.m_arlen, 8'd3);
        chk("hold_m_arsize",  bus.m_arsize, 3'd2);
        chk("hold_m_arburst", bus.m_arburst, BURST_INCR);
        chk("hold_s0_arready", bus.s0_arready, 0);

        // stalled manager: payload stable, no grants even with both requesting
        bus.s0_arvalid = 1'b1; bus.s0_araddr = 32'h999;
        bus.s1_arid = 4'h2; bus.s1_araddr = 32'h200; bus.s1_arvalid = 1'b1;
        bus.m_arready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("stall%0d_m_arvalid", k), bus.m_arvalid, 1);
            chk($sformatf("stall%0d_m_araddr", k),  bus.m_araddr, 32'h100);
            chk($sformatf("stall%0d_arready", k),   {bus.s1_arready, bus.s0_arready}, 0);
            tick();
        end
        bus.s0_araddr = 32'h100;
        bus.m_arready = 1'b1;
        #1;
        chk("hs_no_b2b_arready", {bus.s1_arready, bus.s0_arready}, 0);
        tick();

        // both continuously valid: s1 first (s0 was last), then alternate, 1 grant / 2 cycles
        begin
            logic exp_g;
            exp_g = 1'b1;
            for (int k = 0; k < 8; k++) begin
                #1;
                if (k % 2 == 0) begin
                    chk($sformatf("rr%0d_arready", k), {bus.s1_arready, bus.s0_arready},
                        exp_g ? 2'b10 : 2'b01);
                    chk($sformatf("rr%0d_m_arvalid", k), bus.m_arvalid, 0);
                end else begin
                    chk($sformatf("rr%0d_m_arvalid", k), bus.m_arvalid, 1);
                    chk($sformatf("rr%0d_m_arid", k), bus.m_arid,
                        exp_g ? 5'h12 : 5'h03);
                    chk($sformatf("rr%0d_m_araddr", k), bus.m_araddr,
                        exp_g ? 32'h200 : 32'h100);
                    chk($sformatf("rr%0d_arready", k), {bus.s1_arready, bus.s0_arready}, 0);
                    exp_g = ~exp_g;
                end
                tick();
            end
        end
        bus.s0_arvalid = 1'b0; bus.s1_arvalid = 1'b0; bus.m_arready = 1'b0;

        // reset in HOLD after an s0 grant: output drops at once, next grant is s0
        bus.s0_arvalid = 1'b1;
        tick();
        bus.s0_arvalid = 1'b0;
        #1;
        chk("pre_rst_m_arvalid", bus.m_arvalid, 1);
        #2;
        areset_n = 1'b0;
        #1;
        chk("async_rst_m_arvalid", bus.m_arvalid, 0);
        chk("async_rst_m_arid",    bus.m_arid, 0);
        chk("async_rst_m_araddr",  bus.m_araddr, 0);
        bus.s0_arvalid = 1'b1; bus.s1_arvalid = 1'b1;
        #1;
        chk("in_rst_arready", {bus.s1_arready, bus.s0_arready}, 0);
        areset_n = 1'b1;
        #1;
        chk("post_rst_grant_s0", {bus.s1_arready, bus.s0_arready}, 2'b01);
        tick();
        bus.s0_arvalid = 1'b0; bus.s1_arvalid = 1'b0; bus.m_arready = 1'b1;
        tick();
        bus.m_arready = 1'b0;

`ifdef JUX_AXI4_RD_ARB_OUTST_LIMIT_EN
        // fresh counters, then fill s0 to the limit of 4
        areset_n = 1'b0;
        #3;
        areset_n = 1'b1;
        tick();
        bus.m_arready = 1'b1;
        bus.s0_arvalid = 1'b1;
        for (int b = 0; b < 4; b++) begin
            #1;
            chk($sformatf("lim_grant%0d", b), bus.s0_arready, 1);
            tick();
            tick();
        end
        #1;
        chk("lim_s0_blocked", bus.s0_arready, 0);
        bus.s1_arvalid = 1'b1;
        #1;
        chk("lim_s1_granted", {bus.s1_arready, bus.s0_arready}, 2'b10);
        tick();
        bus.s1_arvalid = 1'b0;
        tick();
        #1;
        chk("lim_s0_still_blocked", bus.s0_arready, 0);
        bus.m_rid = 5'h01; bus.m_rlast = 1'b1; bus.m_rvalid = 1'b1; bus.s0_rready = 1'b1;
        tick();
        bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0; bus.s0_rready = 1'b0;
        #1;
        chk("lim_s0_released", bus.s0_arready, 1);
        bus.s0_arvalid = 1'b0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jux_axi4_rd_arb.md
JUX_AXI4_RD_ARB -- requirements
Module: jux_axi4_rd_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 2: data bus is (1 << DATA_WIDTH) bytes.
REQ-002 Parameter ADDR_WIDTH, default 32: address width in bits.
REQ-003 Parameter ID_WIDTH, default 4: requester-side ID width; the manager side is ID_WIDTH+1.
REQ-004 Parameter AXLEN_WIDTH, default 8: ARLEN width (AXI4).
REQ-005 Parameter MAX_OUTST, default 4: maximum outstanding read bursts per requester.
REQ-006 Port aclk, input, 1: the single clock; all logic is rising-edge.
REQ-007 Port areset_n, input, 1: asynchronous, active-low reset.
REQ-008 Ports s<n>_arid/araddr/arlen/arsize/arburst, n=0,1, input, ID_WIDTH/ADDR_WIDTH/AXLEN_WIDTH/3/2: requester AR payload.
REQ-009 Ports s<n>_arvalid input 1 and s<n>_arready output 1: requester AR handshake.
REQ-010 Ports m_arid (output, ID_WIDTH+1) and m_araddr/arlen/arsize/arburst (output): the shared AR payload.
REQ-011 Ports m_arvalid output 1 and m_arready input 1: shared AR handshake.
REQ-012 Ports m_rid (input, ID_WIDTH+1), m_rdata (input, 8<<DATA_WIDTH), m_rresp (input, 2), m_rlast/m_rvalid (input, 1) and m_rready (output, 1): shared R channel.
REQ-013 Ports s<n>_rid/rdata/rresp/rlast/rvalid (output) and s<n>_rready (input): per-requester R channel.

Function
REQ-014 The AR arbiter SHALL be an FSM with two states: IDLE (m_arvalid=0) and HOLD (m_arvalid=1).
REQ-015 In IDLE with any eligible s<n>_arvalid, the arbiter SHALL grant one requester round-robin, starting from the requester after the last grant.
REQ-016 On grant, the arbiter SHALL pulse s<n>_arready for 1 cycle, register the payload into the m_ar* outputs and enter HOLD, so m_arvalid rises 1 cycle after acceptance.
REQ-017 m_arid SHALL equal {n, s<n>_arid}, where the MSB is the requester index.
REQ-018 In HOLD, the m_ar* outputs SHALL remain stable until m_arready=1; at that handshake the FSM SHALL return to IDLE, with no back-to-back grant in the same cycle.
REQ-019 If both requesters are valid in IDLE, the grant SHALL go to the requester not granted last; the first grant after reset goes to s0.
REQ-020 The R path SHALL be combinational: route every m_r* field to s<m_rid[ID_WIDTH]>, with s_rid = m_rid[ID_WIDTH-1:0].
REQ-021 m_rready SHALL equal s<m_rid[ID_WIDTH]>_rready; the unselected s<n>_rvalid SHALL be 0.
REQ-022 s<n>_arready SHALL be 0 in HOLD; a requester deasserting arvalid before grant SHALL be allowed and ignored.

Reset
REQ-023 While areset_n=0, the block SHALL drive m_arvalid=0, s<n>_arready=0, all m_ar* payload=0, FSM=IDLE, RR pointer=s0 and all counters=0, asynchronously.
REQ-024 Reset deassertion SHALL take effect at the next aclk edge; a burst in flight at reset is discarded and not tracked.

Configuration
REQ-025 With macro JUX_AXI4_RD_ARB_OUTST_LIMIT_EN defined, the block SHALL keep one counter per requester, $clog2(MAX_OUTST+1) bits wide.
REQ-026 The counter SHALL increment on that requester's AR handshake (m_arvalid && m_arready with matching MSB) and decrement on its R handshake with rlast=1.
REQ-027 If increment and decrement occur in the same cycle, the counter SHALL remain unchanged.
REQ-028 A requester whose count equals MAX_OUTST SHALL be ineligible for grant.
REQ-029 Counter underflow or overflow SHALL NOT occur, and SHALL be asserted against.
REQ-030 Without the macro, no counters SHALL exist, and every valid requester is eligible.

Structure
REQ-031 Package jux_axi4_pkg SHALL hold the arbiter FSM state enum, the AXI burst/resp encodings and the requester-index width constant.
REQ-032 The round-robin grant logic SHALL be sub-module jux_rr_arb2 (req[1:0], ack, grant[1:0], pointer register).

Verification
REQ-033 Scenario: s0 valid alone, id=3, addr=0x100 -> s0_arready pulses at cycle 1, m_arvalid=1 at cycle 2 with m_arid=0x03, held until m_arready.
REQ-034 Scenario: s0 and s1 continuously valid, m_arready=1 -> grants alternate s0,s1,s0,s1, with one grant every 2 cycles.
REQ-035 Scenario: m_arready held 0 for 5 cycles in HOLD -> m_ar* stable and both s_arready=0 throughout.
REQ-036 Scenario: m_rid=0x12, rlast=1, s1_rready=0 -> s1_rvalid=1, s1_rid=0x2, m_rready=0, s0_rvalid=0.
REQ-037 Scenario (macro on, MAX_OUTST=4): 4 s0 bursts granted with no R -> 5th s0 request is blocked while s1 is still granted; one s0 rlast handshake -> s0 is eligible next cycle.
REQ-038 Scenario: areset_n asserted mid-HOLD -> m_arvalid=0 immediately; after release, the first grant goes to s0.
